// File: rtl/parity_sched_pkg.sv
// Shared types and width helpers for the round-robin parity scheduler.
package parity_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Index width for a field addressing n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int ID_W_DEF  = idx_width(NREQ_DEF);
  localparam int CNT_W_DEF = idx_width(WIDTH_DEF);

endpackage

// File: rtl/serial_parity_engine.sv
// Single-flop bit-serial parity accumulator: toggles on each 1 bit, cleared by reset or clr.
module serial_parity_engine (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic in,
  output logic out
);

  // Parity accumulator flop
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      out <= 1'b0;
    end else if (in) begin
      out <= ~out;
    end else begin
      out <= out;
    end
  end

endmodule

// File: rtl/parity_scheduler.sv
// Round-robin front end sharing one serial parity engine among NREQ requesters.
// Optional expected-parity checking is built when PARITY_SCHED_CHECK_EN is defined.
module parity_scheduler
  import parity_sched_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int ID_W  = idx_width(NREQ),
  localparam int CNT_W = idx_width(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic                  parity_out
`ifdef PARITY_SCHED_CHECK_EN
  ,
  input  logic [NREQ-1:0]       exp_par,
  output logic                  par_err
`endif
);

  state_t            state_r, next_state_s;
  logic [WIDTH-1:0]  shreg_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ID_W-1:0]   id_r, last_r, gidx_s;
  logic [ID_W:0]     cand_s;
  logic              found_s;
  logic [WIDTH-1:0]  word_s;
  logic              eng_in_s, eng_out_s, clr_s;
`ifdef PARITY_SCHED_CHECK_EN
  logic              exp_r;
`endif

  // Round-robin pick: first asserted req searching upward from last+1, wrapping
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    cand_s  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand_s = {1'b0, last_r} + (ID_W+1)'(off);
      if (cand_s >= (ID_W+1)'(NREQ)) begin
        cand_s = cand_s - (ID_W+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s[ID_W-1:0]]) begin
        found_s = 1'b1;
        gidx_s  = cand_s[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign word_s   = data[gidx_s*WIDTH +: WIDTH];
  assign clr_s    = (state_r == IDLE) && found_s;
  assign eng_in_s = (state_r == SHIFT) ? shreg_r[cnt_r] : 1'b0;

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(WIDTH-1)) begin
          next_state_s = REPORT;
        end else begin
          next_state_s = SHIFT;
        end
      end
      REPORT:  next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Job state, round-robin pointer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      shreg_r    <= '0;
      cnt_r      <= '0;
      id_r       <= '0;
      last_r     <= ID_W'(NREQ-1);
      gnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      parity_out <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      gnt        <= '0;
      busy       <= (state_r == SHIFT) || (state_r == REPORT);
      done       <= (state_r == REPORT);
      done_id    <= (state_r == REPORT) ? id_r : '0;
      parity_out <= (state_r == REPORT) ? eng_out_s : 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << gidx_s;
            shreg_r <= word_s;
            id_r    <= gidx_s;
            last_r  <= gidx_s;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        SHIFT:   cnt_r <= cnt_r + CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

`ifdef PARITY_SCHED_CHECK_EN
  // Expected parity latched with the word; mismatch flagged only in the report cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_r   <= 1'b0;
      par_err <= 1'b0;
    end else begin
      exp_r   <= clr_s ? exp_par[gidx_s] : exp_r;
      par_err <= (state_r == REPORT) ? (eng_out_s ^ exp_r) : 1'b0;
    end
  end
`endif

  serial_parity_engine u_engine (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .in    (eng_in_s),
    .out   (eng_out_s)
  );

endmodule

// File: doc/parity_scheduler.md
Name: parity_scheduler

Overview:
- Shares one bit-serial parity engine between NREQ requesters.
- Each requester submits a parallel WIDTH-bit word.
- Block arbitrates round-robin, latches the granted word, clears the engine, shifts the word in LSB-first (one bit per clock), then reports the parity result with a one-cycle done pulse.
- Sits between the parallel producers and the serial parity engine, which it instantiates.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, word width in bits (2..32).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- data  in  NREQ*WIDTH  flattened words; requester i owns bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, one-cycle pulse.
- busy  out  1  high while a job is in flight (SHIFT or REPORT).
- done  out  1  one-cycle result-valid pulse.
- done_id  out  $clog2(NREQ)  index of requester whose result is on parity_out.
- parity_out  out  1  XOR of all WIDTH bits of the served word (1 = odd number of ones); valid only when done=1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: gnt=0, busy=0, done=0, done_id=0, parity_out=0, state=IDLE, rr pointer last=NREQ-1 (requester 0 wins first), engine state=0.
- States:
  - IDLE: on an edge with any req bit high:
    - pick the first requester searching from last+1, wrapping modulo NREQ;
    - register gnt one-hot for exactly one cycle;
    - latch that requester's word into the shift register and its index into id;
    - clear the engine; set last=index; go to SHIFT with bit counter=0.
    - With no req, stay in IDLE with all outputs 0.
  - SHIFT: feed shift-register bit[cnt] into the engine each cycle; cnt increments from 0 to WIDTH-1. After bit WIDTH-1 is consumed, go to REPORT.
  - REPORT: done=1, parity_out=engine state, done_id=id for one cycle; then go to IDLE.
- Timing: gnt is high in cycle G. done is high in cycle G+WIDTH+1. The next grant is at earliest cycle G+WIDTH+2.
- busy is high from cycle G+1 through the REPORT cycle inclusive.
- Handshake:
  - data is sampled only on the grant edge; changes afterward have no effect.
  - A requester may deassert req at any time before grant; it is then not granted.
  - req of any requester is ignored outside IDLE.
  - A requester keeping req high is re-arbitrated normally in the next IDLE (fairness via pointer).
- Engine: a single flip-flop toggled when in=1, held when in=0, cleared by (reset | clr).
- Reset mid-job: the job is dropped and no done is issued; the next cycle shows reset values.

Optional Feature:
- Macro: PARITY_SCHED_CHECK_EN.
- Defined:
  - adds input exp_par[NREQ], latched with the word at grant;
  - adds output par_err, high only in the REPORT cycle when parity_out != latched exp_par; 0 otherwise and at reset.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package parity_sched_pkg holds the state encoding (IDLE, SHIFT, REPORT) and the clog2-based width constants for id and the bit counter.
- One sub-module, serial_parity_engine (clk, reset, clr, in, out), is instantiated once.
- Round-robin selection stays inline.

Test Plan:
- req=0010, data1=8'b1011_0001 (4 ones) -> gnt=0010 for one cycle; done 9 cycles later with done_id=1, parity_out=0.
- req=0001, data0=8'hFE -> done with done_id=0, parity_out=1; busy high exactly 9 cycles.
- After reset, req=1111 held -> grant order 0,1,2,3,0; then req=0101 after 0 served -> 2 then 0.
- Reset asserted in SHIFT at cnt=3 -> no done; next cycle all outputs 0; a following req=1000 is served with pointer restarted (req=1001 -> 0 first).
- data0 changed from 8'h01 to 8'h00 one cycle after gnt -> parity_out=1 (latched value used).
- PARITY_SCHED_CHECK_EN: data2=8'h07, exp_par[2]=0 -> par_err=1 in the done cycle; exp_par[2]=1 -> par_err=0.
